// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority pick: first set bit of req_masked starting at ptr, wrapping mod 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_masked,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Walk from the farthest offset down so the closest-to-ptr hit wins last.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req_masked[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter sharing one DATA_W datapath among four requesters.
// Define ARB_HOLD_LIMIT_EN to cap each grant at MAX_HOLD consecutive cycles.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    output logic [N_REQ-1:0]  gnt,
    output logic [SEL_W-1:0]  rsel,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy
);

    arb_state_t       state, state_n;
    logic [SEL_W-1:0] owner, owner_n, ptr, ptr_n;
    logic [N_REQ-1:0] pick_req, rel_mask;
    logic [SEL_W-1:0] pick_ptr, pick_idx;
    logic             pick_found, expire, release_c;
    logic [DATA_W-1:0] owner_data;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [HC_W-1:0] hold_cnt;
    logic            restart;

    assign expire  = (hold_cnt == HC_W'(MAX_HOLD - 1));
    assign restart = (state_n == GRANT) && ((state == IDLE) || release_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_cnt <= '0;
        else if (restart)
            hold_cnt <= '0;
        else if (state == GRANT)
            hold_cnt <= hold_cnt + HC_W'(1);
    end
`else
    assign expire = 1'b0;
`endif

    assign release_c = !req[owner] || expire;

    // On expiry the owner steps aside unless nobody else is waiting.
    always_comb begin
        rel_mask = req;
        if (expire && ((req & ~onehot(owner)) != '0))
            rel_mask[owner] = 1'b0;
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        ptr_n    = ptr;
        pick_req = req;
        pick_ptr = ptr;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = GRANT;
                    owner_n = pick_idx;
                end
            end
            GRANT: begin
                pick_req = rel_mask;
                pick_ptr = owner + SEL_W'(1);
                if (release_c) begin
                    ptr_n = owner + SEL_W'(1);
                    if (pick_found)
                        owner_n = pick_idx;
                    else
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    rr_pick4 u_pick (
        .req_masked (pick_req),
        .ptr        (pick_ptr),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
        end
    end

    always_comb begin
        case (owner)
            2'd0:    owner_data = d0;
            2'd1:    owner_data = d1;
            2'd2:    owner_data = d2;
            default: owner_data = d3;
        endcase
    end

    assign busy    = (state == GRANT);
    assign gnt     = busy ? onehot(owner) : '0;
    assign rsel    = busy ? owner : '0;
    assign q_valid = busy && req[owner];
    assign q       = q_valid ? owner_data : '0;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4 (MAX_HOLD=4); fairness expectations follow ARB_HOLD_LIMIT_EN.
module tb_rr_arbiter_4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] d0, d1, d2, d3;
    logic [3:0]  gnt;
    logic [1:0]  rsel;
    logic [31:0] q;
    logic        q_valid, busy;

    rr_arbiter_4 #(.DATA_W(32), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .gnt     (gnt),
        .rsel    (rsel),
        .q       (q),
        .q_valid (q_valid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [1:0]  rsel;
        logic [31:0] q;
        logic        q_valid;
        logic        busy;
    } obs_t;

    obs_t exp_q[$];
    obs_t e, a;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic obs_t model(input bit bsy, input int own, input logic [3:0] r);
        obs_t        o;
        logic [31:0] dv[4];
        logic [1:0]  oi;
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        oi = own[1:0];
        o  = '0;
        if (bsy) begin
            o.busy    = 1'b1;
            o.gnt     = 4'b0001 << oi;
            o.rsel    = oi;
            o.q_valid = r[oi];
            if (r[oi]) o.q = dv[oi];
        end
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.gnt = gnt; o.rsel = rsel; o.q = q; o.q_valid = q_valid; o.busy = busy;
        return o;
    endfunction

    // Apply this cycle's request vector and queue what the outputs should show.
    task automatic drive(input logic [3:0] r, input bit bsy, input int own);
        req = r;
        exp_q.push_back(model(bsy, own, r));
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [3:0] rt[4] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111};
        bit         bt[4] = '{0, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rst = 1'b0;
            drive(rt[i], bt[i], 0);
            e = exp_q.pop_front(); a = sample(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: got gnt=%b rsel=%0d q=%h qv=%b busy=%b, want gnt=%b rsel=%0d q=%h qv=%b busy=%b",
                         i, a.gnt, a.rsel, a.q, a.q_valid, a.busy, e.gnt, e.rsel, e.q, e.q_valid, e.busy);
            end
            if (i >= 2) begin @(posedge clk); #1; end
            else #1;
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [3:0] rt[5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        bit         bt[5] = '{0, 1, 1, 1, 0};
        int         ot[5] = '{0, 2, 2, 2, 0};
        for (int i = 0; i < 5; i++) begin
            drive(rt[i], bt[i], ot[i]);
            e = exp_q.pop_front(); a = sample(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL single[%0d]: got gnt=%b rsel=%0d q=%h qv=%b busy=%b, want gnt=%b rsel=%0d q=%h qv=%b busy=%b",
                         i, a.gnt, a.rsel, a.q, a.q_valid, a.busy, e.gnt, e.rsel, e.q, e.q_valid, e.busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fairness();
        int own;
        do_reset();
        for (int i = 0; i < 21; i++) begin
`ifdef ARB_HOLD_LIMIT_EN
            own = ((i - 1) / 4) % 4;
`else
            own = 0;
`endif
            drive(4'b1111, i != 0, (i == 0) ? 0 : own);
            e = exp_q.pop_front(); a = sample(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL fairness[%0d]: got gnt=%b rsel=%0d q=%h qv=%b busy=%b, want gnt=%b rsel=%0d q=%h qv=%b busy=%b",
                         i, a.gnt, a.rsel, a.q, a.q_valid, a.busy, e.gnt, e.rsel, e.q, e.q_valid, e.busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_handover();
        logic [3:0] rt[7] = '{4'b0010, 4'b0010, 4'b1011, 4'b1001, 4'b1001, 4'b0000, 4'b0000};
        bit         bt[7] = '{0, 1, 1, 1, 1, 1, 0};
        int         ot[7] = '{0, 1, 1, 1, 3, 3, 0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(rt[i], bt[i], ot[i]);
            e = exp_q.pop_front(); a = sample(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL handover[%0d]: got gnt=%b rsel=%0d q=%h qv=%b busy=%b, want gnt=%b rsel=%0d q=%h qv=%b busy=%b",
                         i, a.gnt, a.rsel, a.q, a.q_valid, a.busy, e.gnt, e.rsel, e.q, e.q_valid, e.busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sole_expiry();
        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive((i <= 10) ? 4'b0010 : 4'b0000, (i != 0) && (i != 12), 1);
            e = exp_q.pop_front(); a = sample(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL sole[%0d]: got gnt=%b rsel=%0d q=%h qv=%b busy=%b, want gnt=%b rsel=%0d q=%h qv=%b busy=%b",
                         i, a.gnt, a.rsel, a.q, a.q_valid, a.busy, e.gnt, e.rsel, e.q, e.q_valid, e.busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] rt[7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0101, 4'b0000, 4'b0000};
        bit         bt[7] = '{0, 1, 1, 0, 1, 1, 0};
        int         ot[7] = '{0, 2, 2, 0, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                // Mid-cycle pulse while requester 2 holds the grant.
                rst = 1'b1;
                exp_q.push_back(model(0, 0, req));
                #1;
                e = exp_q.pop_front(); a = sample(); vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL async_rst: got gnt=%b rsel=%0d q=%h qv=%b busy=%b, want gnt=%b rsel=%0d q=%h qv=%b busy=%b",
                             a.gnt, a.rsel, a.q, a.q_valid, a.busy, e.gnt, e.rsel, e.q, e.q_valid, e.busy);
                end
                rst = 1'b0;
            end
            drive(rt[i], bt[i], ot[i]);
            e = exp_q.pop_front(); a = sample(); vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL async[%0d]: got gnt=%b rsel=%0d q=%h qv=%b busy=%b, want gnt=%b rsel=%0d q=%h qv=%b busy=%b",
                         i, a.gnt, a.rsel, a.q, a.q_valid, a.busy, e.gnt, e.rsel, e.q, e.q_valid, e.busy);
            end
            if (i != 2) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        d0  = 32'h0A0A_0A0A;
        d1  = 32'h1111_1111;
        d2  = 32'hDEAD_BEEF;
        d3  = 32'h3333_3333;
        test_reset();
        test_single();
        test_fairness();
        test_handover();
        test_sole_expiry();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
